// File: rtl/fibonacci_pkg.sv
// fibonacci_pkg
// Shared widths and state encoding for the Fibonacci forward/inverse blocks.
//   FIB_W       : data width of values and results (16)
//   FIB_ACC_W   : accumulator width, wide enough that F(26) cannot wrap (17)
//   FIB_IDX_W   : index counter width, holds 0..25 (5)
//   FIB_MAX_IDX : largest index whose term fits in FIB_W bits (24)
//   fib_inv_state_t : FSM states of fibonacci_index
package fibonacci_pkg;

  localparam int unsigned FIB_W       = 16;
  localparam int unsigned FIB_ACC_W   = 17;
  localparam int unsigned FIB_IDX_W   = 5;
  localparam int unsigned FIB_MAX_IDX = 24;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StDone   = 2'd2
  } fib_inv_state_t;

endpackage

// File: rtl/fibonacci_index.sv
// fibonacci_index
// Inverse Fibonacci: walks F(0), F(1), ... one term per clock until the term equals or
// exceeds the captured target, then reports the index and whether the value was a term.
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; aborts any search with no result
//   din   : value to invert, sampled only on an accepted start
//   start : one-cycle request; accepted in idle or done, ignored while searching
//   dout  : resulting index, zero-extended (0..24)
//   done  : high while the result is valid, until the next accepted start
//   found : 1 when din is a Fibonacci number, valid while done=1
//
// Configuration macro FIB_INV_FLOOR_EN:
//   defined   -> on not-found, dout is the largest index with F(index) < din
//   undefined -> on not-found, dout is 0
module fibonacci_index
  import fibonacci_pkg::*;
#(
  parameter int unsigned DATA_W = FIB_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              start,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              found
);

  fib_inv_state_t         r_state;
  logic [DATA_W-1:0]      r_tgt;
  logic [FIB_ACC_W-1:0]   r_a;      // F(r_n)
  logic [FIB_ACC_W-1:0]   r_b;      // F(r_n + 1)
  logic [FIB_IDX_W-1:0]   r_n;
  logic [DATA_W-1:0]      r_dout;
  logic                   r_done;
  logic                   r_found;

  logic [FIB_ACC_W-1:0]   w_tgt_ext;
  logic [FIB_ACC_W-1:0]   w_sum;
  logic                   w_hit;
  logic                   w_over;
  logic [DATA_W-1:0]      w_n_ext;
  logic [DATA_W-1:0]      w_miss_idx;

  assign w_tgt_ext = FIB_ACC_W'(r_tgt);
  assign w_sum     = r_a + r_b;
  assign w_hit     = (r_a == w_tgt_ext);
  assign w_over    = (r_a > w_tgt_ext);
  assign w_n_ext   = DATA_W'(r_n);

`ifdef FIB_INV_FLOOR_EN
  // Overshoot only happens once r_n >= 1 (F(0)=0 never exceeds a target), so no underflow.
  assign w_miss_idx = w_n_ext - DATA_W'(1);
`else
  assign w_miss_idx = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_tgt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_n     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_tgt   <= din;
            r_a     <= '0;
            r_b     <= FIB_ACC_W'(1);
            r_n     <= '0;
            r_done  <= 1'b0;
            r_found <= 1'b0;
            r_state <= StSearch;
          end
        end
        StSearch: begin
          if (w_hit) begin
            r_dout  <= w_n_ext;
            r_found <= 1'b1;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else if (w_over) begin
            r_dout  <= w_miss_idx;
            r_found <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_a <= r_b;
            r_b <= w_sum;
            r_n <= r_n + FIB_IDX_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dout  = r_dout;
  assign done  = r_done;
  assign found = r_found;

  // Any reported index must fit the sequence range representable in DATA_W bits.
  assert property (@(posedge clk) disable iff (reset)
                   r_done |-> (r_dout <= DATA_W'(FIB_MAX_IDX)));

endmodule

// File: tb/tb_fibonacci_index.sv
module tb_fibonacci_index;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        start;
  logic [15:0] dout;
  logic        done;
  logic        found;

  int n_checks;
  int n_fails;

  fibonacci_index dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .start (start),
    .dout  (dout),
    .done  (done),
    .found (found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic        found;
    int          lat;
  } vec_t;

`ifdef FIB_INV_FLOOR_EN
  localparam logic [15:0] Miss100   = 16'd11;
  localparam logic [15:0] Miss65535 = 16'd24;
`else
  localparam logic [15:0] Miss100   = 16'd0;
  localparam logic [15:0] Miss65535 = 16'd0;
`endif

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one cycle; leaves the bench #1 after the capturing edge E0.
  task automatic pulse_start(input logic [15:0] value);
    @(posedge clk);
    #1;
    din   = value;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after E0 until done rises; returns 0 if it never does within the bound.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    pulse_start(v.din);
    wait_done(lat);
    check({name, " latency"}, lat, v.lat);
    check({name, " dout"}, int'(dout), int'(v.dout));
    check({name, " found"}, int'(found), int'(v.found));
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_fails  = 0;
    din   = '0;
    start = 1'b0;
    reset = 1'b1;

    vecs[0] = '{din: 16'd5,     dout: 16'd5,  found: 1'b1, lat: 6};
    vecs[1] = '{din: 16'd144,   dout: 16'd12, found: 1'b1, lat: 13};
    vecs[2] = '{din: 16'd4181,  dout: 16'd19, found: 1'b1, lat: 20};
    vecs[3] = '{din: 16'd46368, dout: 16'd24, found: 1'b1, lat: 25};
    vecs[4] = '{din: 16'd0,     dout: 16'd0,  found: 1'b1, lat: 1};
    vecs[5] = '{din: 16'd1,     dout: 16'd1,  found: 1'b1, lat: 2};
    vecs[6] = '{din: 16'd2,     dout: 16'd3,  found: 1'b1, lat: 4};
    vecs[7] = '{din: 16'd100,   dout: Miss100,   found: 1'b0, lat: 13};
    vecs[8] = '{din: 16'd65535, dout: Miss65535, found: 1'b0, lat: 26};
    vecs[9] = '{din: 16'd3,     dout: 16'd4,  found: 1'b1, lat: 5};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset dout", int'(dout), 0);
    check("reset done", int'(done), 0);
    check("reset found", int'(found), 0);

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d din=%0d", i, vecs[i].din), vecs[i]);
    end

    // Start during SEARCH is ignored: the original target still completes on time.
    pulse_start(16'd4181);
    repeat (2) @(posedge clk);
    #1;
    din   = 16'd21;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int c = 4; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    check("ignored start latency", lat, 20);
    check("ignored start dout", int'(dout), 19);
    check("ignored start found", int'(found), 1);

    // Restart from DONE: done drops right after the capturing edge.
    pulse_start(16'd21);
    check("restart done low", int'(done), 0);
    wait_done(lat);
    check("restart latency", lat, 9);
    check("restart dout", int'(dout), 8);
    check("restart found", int'(found), 1);

    // Reset mid-search aborts with no result.
    pulse_start(16'd4181);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset dout", int'(dout), 0);
    check("midreset done", int'(done), 0);
    check("midreset found", int'(found), 0);
    repeat (25) @(posedge clk);
    #1;
    check("midreset stays idle", int'(done), 0);
    run_vec("after reset din=8", '{din: 16'd8, dout: 16'd6, found: 1'b1, lat: 7});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
